regfile_ctrl: RTL and testbench

Instruction sequencer for the 8 x 16-bit `regfile`. It accepts one 16-bit instruction at a time over a valid/ready handshake. It drives the regfile's `write`/`writenum`/`readnum`/`data_in` ports and reads its `data_out`. Internal A/B/C registers, a shifter and an ALU execute MOV/ADD/CMP/AND/MVN, and CMP updates status flags. It sits between the instruction source and the regfile.

---
 rtl/regfile_ctrl.sv | 170 +++++++++++++++++
 tb/tb_regfile_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctrl.sv
// Instruction sequencer for the 8 x 16-bit regfile: fetches operands through the
// read port, runs them through the shifter and ALU, and writes results back.
module regfile_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  output logic        rf_write,
  output logic [2:0]  rf_writenum,
  output logic [2:0]  rf_readnum,
  output logic [15:0] rf_data_in,
  input  logic [15:0] rf_data_out,
  output logic        done,
  output logic        err,
  output logic        Z,
  output logic        N,
  output logic        V
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_RDA,
    S_RDB,
    S_EXEC,
    S_WB,
    S_WIMM
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic [15:0] a_reg, b_reg, c_reg;
  logic [15:0] b_sh, diff, alu_out;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movi, is_movr, is_add, is_cmp, is_and, is_mvn;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_add  = (opcode == 3'b101) && (op == 2'b00);
  assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);
  assign is_and  = (opcode == 3'b101) && (op == 2'b10);
  assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);

  always_comb begin
    case (sh)
      2'b00:   b_sh = b_reg;
      2'b01:   b_sh = {b_reg[14:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_reg[15:1]};
      default: b_sh = {b_reg[15], b_reg[15:1]};
    endcase
  end

  // MOV reg shares the ALU path as a plain pass-through of the shifted B operand.
  always_comb begin
    diff    = a_reg - b_sh;
    alu_out = b_sh;
    if (opcode == 3'b101) begin
      case (op)
        2'b00:   alu_out = a_reg + b_sh;
        2'b01:   alu_out = diff;
        2'b10:   alu_out = a_reg & b_sh;
        default: alu_out = ~b_sh;
      endcase
    end
  end

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is high only in IDLE and never in reset.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    rf_write    = 1'b0;
    rf_writenum = 3'd0;
    rf_readnum  = 3'd0;
    rf_data_in  = 16'd0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi)                        state_nxt = S_WIMM;
        else if (is_movr || is_mvn)         state_nxt = S_RDB;
        else if (is_add || is_cmp || is_and) state_nxt = S_RDA;
        else begin
          done      = 1'b1;
          err       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RDA: begin
        rf_readnum = rn;
        state_nxt  = S_RDB;
      end
      S_RDB: begin
        rf_readnum = rm;
        state_nxt  = S_EXEC;
      end
      S_EXEC: begin
        if (is_cmp) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        rf_write    = 1'b1;
        rf_writenum = rd;
        rf_data_in  = c_reg;
        done        = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_WIMM: begin
        rf_write    = 1'b1;
        rf_writenum = rn;
        rf_data_in  = {{8{ir[7]}}, ir[7:0]};
        done        = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Reset suppresses every strobe, so an in-flight WB/WIMM never commits.
    if (reset) begin
      in_ready = 1'b0;
      rf_write = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= 16'd0;
      a_reg <= 16'd0;
      b_reg <= 16'd0;
      c_reg <= 16'd0;
      Z     <= 1'b0;
      N     <= 1'b0;
      V     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_ready && in_valid) ir <= instr;
      if (state == S_RDA) a_reg <= rf_data_out;
      if (state == S_RDB) b_reg <= rf_data_out;
      if (state == S_EXEC) begin
        c_reg <= alu_out;
        if (is_cmp) begin
          Z <= (diff == 16'd0);
          N <= diff[15];
          V <= (a_reg[15] ^ b_sh[15]) & (diff[15] ^ a_reg[15]);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural 8 x 16 regfile attached
// and a write scoreboard fed with hand-computed expected writes.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        rf_write;
  logic [2:0]  rf_writenum;
  logic [2:0]  rf_readnum;
  logic [15:0] rf_data_in;
  logic [15:0] rf_data_out;
  logic        done, err, Z, N, V;

  regfile_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rf_write    (rf_write),
    .rf_writenum (rf_writenum),
    .rf_readnum  (rf_readnum),
    .rf_data_in  (rf_data_in),
    .rf_data_out (rf_data_out),
    .done        (done),
    .err         (err),
    .Z           (Z),
    .N           (N),
    .V           (V)
  );

  // clock / regfile model
  always #5 clk = ~clk;

  logic [15:0] regs [0:7];
  logic        rf_clr;
  assign rf_data_out = regs[rf_readnum];

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
    end else if (rf_write) begin
      regs[rf_writenum] <= rf_data_in;
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [18:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rf_write) begin
      logic [31:0] e;
      e = (exp_q.size() > 0) ? {13'd0, exp_q.pop_front()} : 32'hDEAD_BEEF;
      check("rf_write_event", {13'd0, rf_writenum, rf_data_in}, e);
    end
  end

  // driver
  int         busy_cyc, wr_cnt, done_cnt, err_cnt, done_idx;
  logic [2:0] rd_log [0:19];

  task automatic send(input logic [15:0] ins);
    bit finished;
    finished = 1'b0;
    busy_cyc = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; done_idx = -1;
    instr    = ins;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    instr = 16'hE000;  // illegal word offered while busy must be ignored
    for (int k = 0; k < 20 && !finished; k++) begin
      @(negedge clk);
      if (in_ready) begin
        in_valid = 1'b0;
        finished = 1'b1;
      end else begin
        rd_log[k] = rf_readnum;
        if (rf_write) wr_cnt++;
        if (done) begin done_cnt++; done_idx = k; end
        if (err) err_cnt++;
        busy_cyc++;
      end
    end
    if (!finished) begin
      in_valid = 1'b0;
      check("timeout_in_ready", busy_cyc, 0);
    end
  endtask

  task automatic check_instr(input string tag, input int exp_busy, input int exp_wr, input int exp_err);
    check({tag, "_busy"}, busy_cyc, exp_busy);
    check({tag, "_wr"}, wr_cnt, exp_wr);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_last"}, done_idx, busy_cyc - 1);
    check({tag, "_err"}, err_cnt, exp_err);
  endtask

  logic [15:0] exp_rf [0:7];

  initial begin
    in_valid = 1'b0;
    instr    = 16'd0;
    reset    = 1'b1;
    rf_clr   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_flags", {Z, N, V}, 3'b000);
    reset  = 1'b0;
    rf_clr = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // MOV R0,#-5
    exp_q.push_back({3'd0, 16'hFFFB});
    send(16'hD0FB);
    check_instr("movi_r0", 2, 1, 0);

    exp_q.push_back({3'd1, 16'h0007});
    send(16'hD107);
    check_instr("movi_r1", 2, 1, 0);
    exp_q.push_back({3'd2, 16'h0003});
    send(16'hD203);
    check_instr("movi_r2", 2, 1, 0);

    // ADD R3,R1,R2 LSL1 = 7 + 6
    exp_q.push_back({3'd3, 16'h000D});
    send(16'hA16A);
    check_instr("add_r3", 5, 1, 0);
    check("add_rd_a", rd_log[1], 1);
    check("add_rd_b", rd_log[2], 2);
    check("add_r3_val", regs[3], 16'h000D);
    check("add_flags", {Z, N, V}, 3'b000);

    // CMP R1,R1 then CMP R0(-5),R1(7)
    send(16'hA901);
    check_instr("cmp_eq", 4, 0, 0);
    check("cmp_eq_flags", {Z, N, V}, 3'b100);
    send(16'hA801);
    check_instr("cmp_neg", 4, 0, 0);
    check("cmp_neg_flags", {Z, N, V}, 3'b010);

    // MVN R6,R2 ASR1 ; AND R7,R0,R2
    exp_q.push_back({3'd6, 16'hFFFE});
    send(16'hB8DA);
    check_instr("mvn_r6", 4, 1, 0);
    check("mvn_rd_b", rd_log[1], 2);
    exp_q.push_back({3'd7, 16'h0003});
    send(16'hB0E2);
    check_instr("and_r7", 5, 1, 0);
    check("and_flags_keep", {Z, N, V}, 3'b010);

    exp_rf = '{16'hFFFB, 16'h0007, 16'h0003, 16'h000D,
               16'h0000, 16'h0000, 16'hFFFE, 16'h0003};
    for (int i = 0; i < 8; i++) check($sformatf("readback_r%0d", i), regs[i], exp_rf[i]);

    // illegal opcode
    send(16'hE000);
    check_instr("illegal", 1, 0, 1);

    // reset asserted for one cycle while an ADD to R3 sits in RDB
    in_valid = 1'b1;
    instr    = 16'hA16A;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_wr", rf_write, 0);
    check("midrst_done", done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("postmid_in_ready", in_ready, 1);
    check("postmid_done", done, 0);
    check("postmid_flags", {Z, N, V}, 3'b000);
    check("postmid_r3", regs[3], 16'h000D);

    // back-to-back after the abort
    exp_q.push_back({3'd4, 16'hFF80});
    send(16'hD480);
    check_instr("b2b_movi_r4", 2, 1, 0);
    exp_q.push_back({3'd5, 16'h7FC0});
    send(16'hC0B4);
    check_instr("b2b_movr_r5", 4, 1, 0);
    exp_q.push_back({3'd3, 16'h7F40});
    send(16'hA465);
    check_instr("b2b_add_r3", 5, 1, 0);
    check("b2b_r3_val", regs[3], 16'h7F40);
    // 0x7FC0 - 0xFF80 = 0x8040: positive minus negative overflows
    send(16'hAD04);
    check_instr("cmp_ovf", 4, 0, 0);
    check("cmp_ovf_flags", {Z, N, V}, 3'b011);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
